// File: rtl/select_controller_if.sv
// Button and board-state bundle of the drop-piece game controller.
// The controller takes the slave view; the stimulus side takes the master view.
interface select_controller_if;
  logic        left;
  logic        right;
  logic        middle;
  logic [97:0] grid;
  logic        player;
  logic [2:0]  cursor;
  logic        busy;
  logic        game_over;
  logic [1:0]  winner;

  modport master (
    output left, right, middle,
    input  grid, player, cursor, busy, game_over, winner
  );

  modport slave (
    input  left, right, middle,
    output grid, player, cursor, busy, game_over, winner
  );
endinterface

// File: rtl/select_controller.sv
// Drop-piece game controller on a 7x7 board.
// Pieces fall to the lowest empty cell of the cursor column. A line of
// WIN_LEN same-player pieces through the newest piece wins, and a full
// board with no winner is a draw.
module select_controller #(
  parameter int WIN_LEN = 4
) (
  input logic               clk,
  input logic               rst,
  select_controller_if.slave bus
);

  typedef enum logic [2:0] {IDLE, FIND, PLACE, CHECK, SWITCH, DONE} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  board_reg [49];
  logic [1:0]  board_next [49];
  logic        player_reg, player_next;
  logic [2:0]  cursor_reg, cursor_next;
  logic [1:0]  winner_reg, winner_next;
  logic [5:0]  moves_reg, moves_next;
  logic [2:0]  col_reg, col_next;      // drop column
  logic [2:0]  row_reg, row_next;      // scan row, then placed row
  logic [1:0]  dir_reg, dir_next;      // 0 horiz, 1 vert, 2 diag, 3 anti-diag
  logic        side_reg, side_next;    // 0 positive walk, 1 negative walk
  logic [2:0]  dist_reg, dist_next;    // distance of neighbour under test
  logic [3:0]  count_reg, count_next;  // run length in current direction
  logic        busy_reg, busy_next;
  logic        over_reg, over_next;

  logic [1:0]        code;
  logic [5:0]        cell_idx;
  logic signed [4:0] row_s, col_s, off, nr, nc;
  logic              in_bounds;
  logic [5:0]        n_idx;
  logic [1:0]        n_cell;
  logic              side_end;
  logic [97:0]       grid_flat;

  assign code     = {player_reg, ~player_reg};
  assign cell_idx = 6'(row_reg) * 6'd7 + 6'(col_reg);

  // Neighbour coordinates for the current walk step, in signed arithmetic so
  // stepping off the board edge is seen as out of bounds rather than wrapping.
  always_comb begin
    row_s = signed'({2'b00, row_reg});
    col_s = signed'({2'b00, col_reg});
    off   = side_reg ? (5'sd0 - signed'({2'b00, dist_reg})) : signed'({2'b00, dist_reg});
    nr    = row_s;
    nc    = col_s;
    case (dir_reg)
      2'd0: begin nr = row_s;       nc = col_s + off; end
      2'd1: begin nr = row_s + off; nc = col_s;       end
      2'd2: begin nr = row_s + off; nc = col_s + off; end
      default: begin nr = row_s + off; nc = col_s - off; end
    endcase
    in_bounds = (nr >= 5'sd0) && (nr <= 5'sd6) && (nc >= 5'sd0) && (nc <= 5'sd6);
    n_idx  = 6'd0;
    if (in_bounds) begin
      n_idx = 6'(nr[2:0]) * 6'd7 + 6'(nc[2:0]);
    end
    n_cell = in_bounds ? board_reg[n_idx] : 2'b00;
  end

  // Next-state and datapath decisions for every FSM state.
  always_comb begin
    state_next  = state_reg;
    board_next  = board_reg;
    player_next = player_reg;
    cursor_next = cursor_reg;
    winner_next = winner_reg;
    moves_next  = moves_reg;
    col_next    = col_reg;
    row_next    = row_reg;
    dir_next    = dir_reg;
    side_next   = side_reg;
    dist_next   = dist_reg;
    count_next  = count_reg;
    side_end    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.middle) begin
          col_next   = cursor_reg;
          row_next   = 3'd6;
          state_next = FIND;
        end else if (bus.left && !bus.right) begin
          cursor_next = (cursor_reg == 3'd0) ? 3'd6 : cursor_reg - 3'd1;
        end else if (bus.right && !bus.left) begin
          cursor_next = (cursor_reg == 3'd6) ? 3'd0 : cursor_reg + 3'd1;
        end
      end

      FIND: begin
        if (board_reg[cell_idx] == 2'b00) begin
          state_next = PLACE;
        end else if (row_reg == 3'd0) begin
          state_next = IDLE;           // column full: nothing changes
        end else begin
          row_next = row_reg - 3'd1;
        end
      end

      PLACE: begin
        board_next[cell_idx] = code;
        dir_next   = 2'd0;
        side_next  = 1'b0;
        dist_next  = 3'd1;
        count_next = 4'd1;
        state_next = CHECK;
      end

      CHECK: begin
        side_end = 1'b1;
        if (in_bounds && (n_cell == code)) begin
          count_next = count_reg + 4'd1;
          if (count_reg + 4'd1 == 4'(WIN_LEN)) begin
            winner_next = code;
            state_next  = DONE;
            side_end    = 1'b0;
          end else if (dist_reg != 3'(WIN_LEN - 1)) begin
            dist_next = dist_reg + 3'd1;
            side_end  = 1'b0;
          end
        end
        if (side_end) begin
          dist_next = 3'd1;
          if (!side_reg) begin
            side_next = 1'b1;          // keep the count, walk the other way
          end else begin
            side_next  = 1'b0;
            count_next = 4'd1;
            if (dir_reg == 2'd3) begin
              state_next = SWITCH;
            end else begin
              dir_next = dir_reg + 2'd1;
            end
          end
        end
      end

      SWITCH: begin
        moves_next = moves_reg + 6'd1;
        if (moves_reg == 6'd48) begin
          winner_next = 2'b11;
          state_next  = DONE;
        end else begin
          player_next = ~player_reg;
          state_next  = IDLE;
        end
      end

      DONE: begin
        state_next = DONE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE) && (state_next != DONE);
    over_next = (state_next == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      for (int i = 0; i < 49; i++) begin
        board_reg[i] <= 2'b00;
      end
      player_reg <= 1'b0;
      cursor_reg <= 3'd3;
      winner_reg <= 2'b00;
      moves_reg  <= 6'd0;
      col_reg    <= 3'd0;
      row_reg    <= 3'd0;
      dir_reg    <= 2'd0;
      side_reg   <= 1'b0;
      dist_reg   <= 3'd1;
      count_reg  <= 4'd1;
      busy_reg   <= 1'b0;
      over_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      board_reg  <= board_next;
      player_reg <= player_next;
      cursor_reg <= cursor_next;
      winner_reg <= winner_next;
      moves_reg  <= moves_next;
      col_reg    <= col_next;
      row_reg    <= row_next;
      dir_reg    <= dir_next;
      side_reg   <= side_next;
      dist_reg   <= dist_next;
      count_reg  <= count_next;
      busy_reg   <= busy_next;
      over_reg   <= over_next;
    end
  end

  // Flatten the board into the packed grid output, cell (r,c) at index 7r+c.
  for (genvar gi = 0; gi < 49; gi++) begin : g_cell
    assign grid_flat[2*gi +: 2] = board_reg[gi];
  end

  assign bus.grid      = grid_flat;
  assign bus.player    = player_reg;
  assign bus.cursor    = cursor_reg;
  assign bus.busy      = busy_reg;
  assign bus.game_over = over_reg;
  assign bus.winner    = winner_reg;

endmodule

// File: tb/tb_select_controller.sv
// Self-checking bench for select_controller: directed scenarios plus random
// games compared with a board-level reference model.
module tb_select_controller;
  localparam int WL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  select_controller_if bus ();

  select_controller #(.WIN_LEN(WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: whole-board view, 0 empty, 1 player 0, 2 player 1.
  int mb [7][7];
  int mplayer, mcursor, mmoves, mwinner;
  bit mover;

  function automatic void m_reset();
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        mb[r][c] = 0;
    mplayer = 0; mcursor = 3; mmoves = 0; mwinner = 0; mover = 1'b0;
  endfunction

  function automatic int m_run(int r, int c, int dr, int dc, int who);
    int n = 0;
    int rr = r + dr;
    int cc = c + dc;
    while (rr >= 0 && rr < 7 && cc >= 0 && cc < 7 && mb[rr][cc] == who) begin
      n++; rr += dr; cc += dc;
    end
    return n;
  endfunction

  function automatic void m_drop(int c);
    int row = -1;
    int who;
    bit win = 1'b0;
    for (int r = 0; r < 7; r++)
      if (mb[r][c] == 0) row = r;
    if (row < 0) return;
    who = mplayer + 1;
    mb[row][c] = who;
    if (1 + m_run(row, c, 0, 1, who) + m_run(row, c, 0, -1, who) >= WL) win = 1'b1;
    if (1 + m_run(row, c, 1, 0, who) + m_run(row, c, -1, 0, who) >= WL) win = 1'b1;
    if (1 + m_run(row, c, 1, 1, who) + m_run(row, c, -1, -1, who) >= WL) win = 1'b1;
    if (1 + m_run(row, c, 1, -1, who) + m_run(row, c, -1, 1, who) >= WL) win = 1'b1;
    if (win) begin
      mwinner = who; mover = 1'b1;
    end else begin
      mmoves++;
      if (mmoves == 49) begin
        mwinner = 3; mover = 1'b1;
      end else begin
        mplayer ^= 1;
      end
    end
  endfunction

  function automatic void m_buttons(bit l, bit r, bit m);
    if (mover) return;
    if (m) m_drop(mcursor);
    else if (l && !r) mcursor = (mcursor + 6) % 7;
    else if (r && !l) mcursor = (mcursor + 1) % 7;
  endfunction

  function automatic logic [97:0] m_grid();
    logic [97:0] g = '0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        g[2*(7*r+c) +: 2] = 2'(mb[r][c]);
    return g;
  endfunction

  // One button transaction in IDLE, then wait out any busy period,
  // optionally hammering random buttons that must be ignored.
  task automatic act(input bit l, input bit r, input bit m, input bit junk, output int cyc);
    @(negedge clk);
    bus.left = l; bus.right = r; bus.middle = m;
    @(negedge clk);
    bus.left = 1'b0; bus.right = 1'b0; bus.middle = 1'b0;
    m_buttons(l, r, m);
    cyc = 0;
    while (bus.busy && cyc < 400) begin
      cyc++;
      if (junk) begin
        bus.left   = 1'($urandom_range(0, 1));
        bus.right  = 1'($urandom_range(0, 1));
        bus.middle = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    bus.left = 1'b0; bus.right = 1'b0; bus.middle = 1'b0;
    checks++;
    if (bus.busy) begin
      failures++;
      $display("FAIL wait_idle busy=%0b after %0d cycles required busy=0", bus.busy, cyc);
    end
    $display("txn l=%0b r=%0b m=%0b busy_cycles=%0d cursor=%0d player=%0b over=%0b winner=%0b",
             l, r, m, cyc, bus.cursor, bus.player, bus.game_over, bus.winner);
  endtask

  task automatic move_to(input int col);
    int cyc;
    for (int k = 0; k < 7 && mcursor != col; k++) act(1'b0, 1'b1, 1'b0, 1'b0, cyc);
  endtask

  task automatic drop(input int col);
    int cyc;
    move_to(col);
    act(1'b0, 1'b0, 1'b1, 1'b0, cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.left = 1'b0; bus.right = 1'b0; bus.middle = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (bus.grid !== 98'd0) begin failures++; $display("FAIL reset_grid got=%h required=0", bus.grid); end
    if (bus.player !== 1'b0) begin failures++; $display("FAIL reset_player got=%0b required=0", bus.player); end
    if (bus.cursor !== 3'd3) begin failures++; $display("FAIL reset_cursor got=%0d required=3", bus.cursor); end
    if (bus.winner !== 2'b00) begin failures++; $display("FAIL reset_winner got=%0b required=00", bus.winner); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b required=0", bus.busy); end
    if (bus.game_over !== 1'b0) begin failures++; $display("FAIL reset_game_over got=%0b required=0", bus.game_over); end
  endtask

  task automatic test_cursor_wrap();
    int cyc;
    do_reset();
    for (int k = 0; k < 4; k++) act(1'b0, 1'b1, 1'b0, 1'b0, cyc);
    checks++;
    if (bus.cursor !== 3'd0) begin failures++; $display("FAIL wrap_right got=%0d required=0", bus.cursor); end
    act(1'b1, 1'b0, 1'b0, 1'b0, cyc);
    checks++;
    if (bus.cursor !== 3'd6) begin failures++; $display("FAIL wrap_left got=%0d required=6", bus.cursor); end
    act(1'b1, 1'b1, 1'b0, 1'b0, cyc);
    checks++;
    if (bus.cursor !== 3'd6) begin failures++; $display("FAIL left_right_same got=%0d required=6", bus.cursor); end
    act(1'b1, 1'b0, 1'b1, 1'b0, cyc);
    checks += 2;
    if (bus.cursor !== 3'd6) begin failures++; $display("FAIL middle_priority_cursor got=%0d required=6", bus.cursor); end
    if (bus.grid !== m_grid()) begin failures++; $display("FAIL middle_priority_grid got=%h required=%h", bus.grid, m_grid()); end
  endtask

  task automatic test_drop_stack();
    do_reset();
    drop(3);
    drop(3);
    checks += 4;
    if (bus.grid[2*(7*6+3) +: 2] !== 2'b01) begin failures++; $display("FAIL stack_bottom got=%0b required=01", bus.grid[2*(7*6+3) +: 2]); end
    if (bus.grid[2*(7*5+3) +: 2] !== 2'b10) begin failures++; $display("FAIL stack_second got=%0b required=10", bus.grid[2*(7*5+3) +: 2]); end
    if (bus.player !== 1'b0) begin failures++; $display("FAIL stack_player got=%0b required=0", bus.player); end
    if (bus.grid !== m_grid()) begin failures++; $display("FAIL stack_grid got=%h required=%h", bus.grid, m_grid()); end
  endtask

  task automatic test_full_column();
    logic [97:0] g_before;
    logic        p_before;
    int          cyc;
    do_reset();
    for (int k = 0; k < 7; k++) drop(0);
    g_before = m_grid();
    p_before = 1'(mplayer);
    checks++;
    if (bus.grid !== g_before) begin failures++; $display("FAIL column_fill_grid got=%h required=%h", bus.grid, g_before); end
    act(1'b0, 1'b0, 1'b1, 1'b0, cyc);
    checks += 4;
    if (cyc != 7) begin failures++; $display("FAIL full_find_cycles got=%0d required=7", cyc); end
    if (bus.grid !== g_before) begin failures++; $display("FAIL full_grid got=%h required=%h", bus.grid, g_before); end
    if (bus.player !== p_before) begin failures++; $display("FAIL full_player got=%0b required=%0b", bus.player, p_before); end
    if (bus.cursor !== 3'd0) begin failures++; $display("FAIL full_cursor got=%0d required=0", bus.cursor); end
  endtask

  task automatic test_vertical_win();
    logic [97:0] g_end;
    int          cols [7] = '{0, 1, 0, 1, 0, 1, 0};
    int          cyc;
    do_reset();
    foreach (cols[k]) drop(cols[k]);
    checks += 2;
    if (bus.game_over !== 1'b1) begin failures++; $display("FAIL vwin_game_over got=%0b required=1", bus.game_over); end
    if (bus.winner !== 2'b01) begin failures++; $display("FAIL vwin_winner got=%0b required=01", bus.winner); end
    g_end = m_grid();
    act(1'b0, 1'b0, 1'b1, 1'b1, cyc);
    act(1'b0, 1'b1, 1'b0, 1'b1, cyc);
    act(1'b0, 1'b0, 1'b1, 1'b1, cyc);
    checks += 4;
    if (bus.grid !== g_end) begin failures++; $display("FAIL done_grid_hold got=%h required=%h", bus.grid, g_end); end
    if (bus.cursor !== 3'd0) begin failures++; $display("FAIL done_cursor_hold got=%0d required=0", bus.cursor); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL done_busy got=%0b required=0", bus.busy); end
    if (bus.winner !== 2'b01) begin failures++; $display("FAIL done_winner_hold got=%0b required=01", bus.winner); end
  endtask

  // Row-by-row fill: colour of (r,c) is ((c/2)+r)%2, which never forms
  // a line longer than two and alternates correctly with the turn order.
  task automatic test_draw();
    int q0[$], q1[$];
    int p = 0;
    do_reset();
    for (int r = 6; r >= 0; r--) begin
      q0.delete(); q1.delete();
      for (int c = 0; c < 7; c++) begin
        if (((c / 2) + r) % 2 == 0) q0.push_back(c);
        else q1.push_back(c);
      end
      for (int k = 0; k < 7; k++) begin
        if (p == 0) drop(q0.pop_front());
        else drop(q1.pop_front());
        p ^= 1;
      end
    end
    checks += 4;
    if (bus.game_over !== 1'b1) begin failures++; $display("FAIL draw_game_over got=%0b required=1", bus.game_over); end
    if (bus.winner !== 2'b11) begin failures++; $display("FAIL draw_winner got=%0b required=11", bus.winner); end
    if (bus.grid !== m_grid()) begin failures++; $display("FAIL draw_grid got=%h required=%h", bus.grid, m_grid()); end
    if (bus.player !== 1'(mplayer)) begin failures++; $display("FAIL draw_player got=%0b required=%0d", bus.player, mplayer); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    act(1'b1, 1'b0, 1'b0, 1'b0, cyc);
    act(1'b0, 1'b0, 1'b1, 1'b0, cyc);
    act(1'b0, 1'b1, 1'b0, 1'b0, cyc);
    @(negedge clk);
    bus.middle = 1'b1;
    @(negedge clk);             // FIND
    bus.middle = 1'b0;
    @(negedge clk);             // PLACE
    @(negedge clk);             // first CHECK
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before got=%0b required=1", bus.busy); end
    @(negedge clk);             // second CHECK executes on the next edge
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    checks += 5;
    if (bus.grid !== 98'd0) begin failures++; $display("FAIL mid_grid got=%h required=0", bus.grid); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b required=0", bus.busy); end
    if (bus.player !== 1'b0) begin failures++; $display("FAIL mid_player got=%0b required=0", bus.player); end
    if (bus.cursor !== 3'd3) begin failures++; $display("FAIL mid_cursor got=%0d required=3", bus.cursor); end
    if (bus.game_over !== 1'b0) begin failures++; $display("FAIL mid_game_over got=%0b required=0", bus.game_over); end
    @(negedge clk);
    rst = 1'b1; bus.middle = 1'b1; bus.right = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.middle = 1'b0; bus.right = 1'b0;
    checks += 2;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_priority_busy got=%0b required=0", bus.busy); end
    if (bus.cursor !== 3'd3) begin failures++; $display("FAIL rst_priority_cursor got=%0d required=3", bus.cursor); end
  endtask

  task automatic test_random_games();
    int cyc;
    int sel;
    bit l, r, m;
    for (int g = 0; g < 3; g++) begin
      do_reset();
      for (int t = 0; t < 120; t++) begin
        sel = $urandom_range(0, 9);
        l = (sel == 0) || (sel == 1) || (sel == 6);
        r = (sel == 2) || (sel == 3) || (sel == 6) || (sel == 7);
        m = (sel >= 4) && (sel != 6);
        act(l, r, m, 1'b1, cyc);
        checks += 5;
        if (bus.grid !== m_grid()) begin failures++; $display("FAIL rand_grid got=%h required=%h", bus.grid, m_grid()); end
        if (bus.player !== 1'(mplayer)) begin failures++; $display("FAIL rand_player got=%0b required=%0d", bus.player, mplayer); end
        if (bus.cursor !== 3'(mcursor)) begin failures++; $display("FAIL rand_cursor got=%0d required=%0d", bus.cursor, mcursor); end
        if (bus.game_over !== mover) begin failures++; $display("FAIL rand_game_over got=%0b required=%0b", bus.game_over, mover); end
        if (bus.winner !== 2'(mwinner)) begin failures++; $display("FAIL rand_winner got=%0b required=%0d", bus.winner, mwinner); end
        if (mover) break;
      end
    end
  endtask

  initial begin
    bus.left = 1'b0; bus.right = 1'b0; bus.middle = 1'b0;
    m_reset();
    test_reset();
    test_cursor_wrap();
    test_drop_stack();
    test_full_column();
    test_vertical_win();
    test_draw();
    test_reset_mid();
    test_random_games();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/select_controller.md
SELECT_CONTROLLER -- requirements
Module: select_controller

Interface
REQ-001 Parameter: WIN_LEN, default 4, the number of same-player pieces in a line needed to win; legal range 2..7.
REQ-002 clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 left  input  1  debounced one-cycle pulse; move the cursor one column left.
REQ-005 right  input  1  debounced one-cycle pulse; move the cursor one column right.
REQ-006 middle  input  1  debounced one-cycle pulse; drop a piece in the cursor column.
REQ-007 grid  output  98  7x7 board, 2 bits per cell.
  - Cell (r,c) is grid[2*(7r+c)+1 : 2*(7r+c)]; r=0 is the top row, r=6 the bottom row.
  - 00 = empty, 01 = player 0, 10 = player 1; 11 is never driven.
REQ-008 player  output  1  the player whose turn it is.
REQ-009 cursor  output  3  selected column, 0..6.
REQ-010 busy  output  1  high in every state except IDLE and DONE.
REQ-011 game_over  output  1  high only in DONE.
REQ-012 winner  output  2  01 = player 0 won, 10 = player 1 won, 11 = draw, 00 = no result.

Function
REQ-013 FSM states: IDLE, FIND, PLACE, CHECK, SWITCH, DONE; all outputs are registered.
REQ-014 IDLE, cursor moves:
  - A left pulse changes cursor c to (c==0 ? 6 : c-1), so it wraps.
  - A right pulse changes cursor c to (c==6 ? 0 : c+1), so it wraps.
  - Each move takes effect on the next cycle.
REQ-015 IDLE, simultaneous pulses:
  - left and right in the same cycle leave the cursor unchanged.
  - middle has priority; left and right are ignored in any cycle where middle is high.
REQ-016 IDLE with middle high: latch the cursor into the drop column, set the scan row to 6 and enter FIND.
REQ-017 FIND checks one cell (row, col) per cycle.
  - If the cell is empty, record the row and go to PLACE.
  - Otherwise decrement the row.
  - If row 0 is occupied (column full), return to IDLE with grid and player unchanged; this takes 7 FIND cycles.
REQ-018 PLACE writes code {player, ~player} into the recorded cell in one cycle, then enters CHECK.
  - Player 0 writes 01; player 1 writes 10.
  - The updated grid is visible on the cycle after PLACE.
REQ-019 CHECK tests directions in this order: horizontal (0,+1), vertical (+1,0), diagonal (+1,+1), anti-diagonal (+1,-1).
REQ-020 CHECK walk rules:
  - For each direction the run count starts at 1, the placed piece.
  - The walk goes in the positive direction, then the negative direction.
  - Each cycle examines one neighbour at distance 1..WIN_LEN-1.
  - A side ends at an out-of-bounds cell, a non-matching cell, or distance WIN_LEN-1.
REQ-021 CHECK outcomes:
  - As soon as the count reaches WIN_LEN, go to DONE with winner set to the placing player's code.
  - If all four directions finish without a win, go to SWITCH.
  - Worst-case CHECK length is 4*2*(WIN_LEN-1) cycles.
REQ-022 Bounds tests use signed, 4-bit-or-wider row/column arithmetic, so a coordinate step from 0 to -1 is detected as out of bounds, never wrapped.
REQ-023 SWITCH:
  - Increment the 6-bit move counter.
  - If it reaches 49, go to DONE with winner=11.
  - Otherwise toggle player and return to IDLE.
REQ-024 While busy or in DONE, left, right and middle are ignored and not queued.
REQ-025 DONE holds grid, player, winner and cursor until rst.

Reset
REQ-026 On rst high at any clock edge, in any state including mid-FIND or mid-CHECK, the next state is as follows.
  - grid = 0, player = 0, cursor = 3, winner = 00.
  - busy = 0, game_over = 0, move counter = 0, state = IDLE.
REQ-027 rst has priority over every button input in the same cycle.

Verification
REQ-028 Cursor wrap: after reset, 4 right pulses -> cursor 0; then 1 left pulse -> cursor 6.
REQ-029 Drop and stack: middle in column 3, wait for IDLE, then middle in column 3 again.
  - grid[2*(7*6+3)+1 : 2*(7*6+3)] = 01.
  - grid[2*(7*5+3)+1 : 2*(7*5+3)] = 10.
  - player = 0.
REQ-030 Full column: fill column 0 with 7 drops, then an 8th middle -> the following all hold.
  - FIND lasts 7 cycles.
  - grid and player are unchanged.
  - The cursor stays at 0.
REQ-031 Vertical win: player 0 drops in columns 0,1,0,1,0,1,0 -> the following all hold.
  - game_over = 1, winner = 01.
  - Further middle pulses leave grid unchanged.
REQ-032 Draw: fill all 49 cells with a sequence that has no 4-in-line -> game_over = 1, winner = 11, move counter = 49.
REQ-033 Reset mid-operation: assert rst on the second CHECK cycle -> the next cycle shows grid = 0, busy = 0, player = 0, cursor = 3.
